parallel_recv: RTL and testbench
================================

PARALLEL_RECV -- requirements
Module: parallel_recv

Interface
REQ-001 CLK  input  1  single clock; all state updates on its rising edge.
REQ-002 RSTX  input  1  asynchronous, active-low reset.
REQ-003 CLR  input  1  synchronous clear; same effect as reset, applied on the next edge.
REQ-004 DIVALID  input  1  DIN carries a new deserialized word this cycle.
REQ-005 DIN  input  64  raw word from the deserializer; word boundary arbitrary.
REQ-006 DOVALID  output  1  DOUT holds a new aligned word.
REQ-007 DOUT  output  64  word-aligned data.
REQ-008 LOCKED  output  1  alignment marker found; OFFSET valid.
REQ-009 OFFSET  output  6  bit offset in use.
REQ-010 CHECKING  output  1  PRBS comparison active.
REQ-011 ERR_CNT  output  16  saturating error count.
REQ-012 RUN_DONE  output  1  one-cycle pulse at the end of a full 1024-word data run.

Function
REQ-013 On DIVALID, prev <= DIN; window = {DIN, prev} (128 bits); aligned(k) = window[k+63:k], k = 0..63.
REQ-014 Marker = 64'hF731_8CEF_137F_FEC8; a hit at k means aligned(k) == marker.
REQ-015 FSM states: HUNT, SEED, CHECK; it advances only on cycles where DIVALID=1.
REQ-016 HUNT: the lowest hit k is written to OFFSET, LOCKED <= 1, next state is SEED. With no hit, the state stays HUNT and OFFSET/LOCKED are held.
REQ-017 SEED: aligned(OFFSET) loads the predictor, word count <= 1, next state is CHECK; no compare in this state.
REQ-018 CHECK: expected = lfsr32x2(predictor); the predictor then loads the received aligned word (not the expected one), so a single bad word costs exactly one error.
REQ-019 CHECK: a mismatch increments ERR_CNT, which saturates at 16'hFFFF.
REQ-020 CHECK: after word 1024 of a run, RUN_DONE pulses and next state is HUNT; LOCKED and OFFSET are held through this.
REQ-021 A marker hit at any offset while in CHECK aborts the run: the new OFFSET is taken, next state is SEED, and no error is counted for that word.
REQ-022 A marker hit in HUNT at an offset different from the held OFFSET replaces OFFSET.
REQ-023 DOUT <= aligned(OFFSET) and DOVALID <= DIVALID & LOCKED, one cycle after DIN; latency is 1.
REQ-024 CHECKING = (state == CHECK).
REQ-025 DIVALID=0 freezes prev, the predictor, the word count, the FSM, and the datapath registers; DOVALID is 0 that cycle.
REQ-026 CLR and DIVALID in the same cycle: CLR wins and the word is discarded.

Reset
REQ-027 Reset and CLR force: state HUNT, prev 0, predictor 0, word count 0, LOCKED 0, OFFSET 0, DOUT 0, DOVALID 0, ERR_CNT 0, RUN_DONE 0.
REQ-028 Reset mid-run discards all progress; relock requires a new marker.

Configuration
REQ-029 With ERR_BITCOUNT_EN defined, each CHECK mismatch adds popcount(expected ^ received) to ERR_CNT, saturating.
REQ-030 Without ERR_BITCOUNT_EN, each mismatching word adds exactly 1.

Structure
REQ-031 A shared package holds: the marker constant, the delay-adjust pattern 64'hAAAA_AAAA_AAAA_AAAA, the data run length 1024, and the FSM state encodings; the transmit side uses the same package.
REQ-032 The predictor instantiates the existing lfsr32x2 sub-module unchanged; the 64-way offset search is a single combinational block with no further sub-module.

Verification
REQ-033 Zero offset: stream 0xAAAA.., then the marker, then 1024 chained-LFSR words, all on DIVALID=1 -> LOCKED=1, OFFSET=0, CHECKING=1 for 1023 compares, ERR_CNT=0, one RUN_DONE pulse.
REQ-034 Shifted stream: same stream shifted by 37 bits -> OFFSET=37, DOUT equals the unshifted words one cycle later, ERR_CNT=0.
REQ-035 Single error: flip bit 5 of data word 100 -> ERR_CNT=1 in word mode, ERR_CNT=1 with ERR_BITCOUNT_EN, and word 101 is not counted as an error.
REQ-036 Gapped input: DIVALID toggles 1,0,0,1 throughout the shifted stream -> results identical to the gapless run, DOVALID pulses only after valid words.
REQ-037 Abort and relock: marker at offset 12 inserted at data word 500 -> SEED re-entered, OFFSET=12, ERR_CNT unchanged.
REQ-038 Clear and saturation: CLR asserted mid-run -> all outputs 0 next cycle; preload a 70000-error stream -> ERR_CNT holds 16'hFFFF.

Source files
------------

// File: rtl/parallel_recv_pkg.sv
// rtl/parallel_recv_pkg.sv - shared link constants, FSM encodings and helpers
// Used by both the receive and transmit sides of the parallel link.
package parallel_recv_pkg;

  localparam logic [63:0] MARKER    = 64'hF731_8CEF_137F_FEC8;
  localparam logic [63:0] DELAY_ADJ = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam int          RUN_LEN   = 1024;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/lfsr32x2.sv
// rtl/lfsr32x2.sv - next 64 bits of an x^32+x^22+x^2+x+1 sequence
// Only the newest 32 bits (seed[63:32]) form the state; bit 0 is the oldest bit.
module lfsr32x2 (
  input  logic [63:0] seed,
  output logic [63:0] word_out
);

  logic [95:0] seq;

  always_comb begin
    seq        = '0;
    seq[31:0]  = seed[63:32];
    for (int j = 0; j < 64; j++) begin
      seq[32+j] = seq[j] ^ seq[j+10] ^ seq[j+30] ^ seq[j+31];
    end
  end

  assign word_out = seq[95:32];

endmodule

// File: rtl/parallel_recv.sv
// rtl/parallel_recv.sv - marker word alignment and PRBS checker for a 64-bit deserializer
// Define ERR_BITCOUNT_EN to count mismatching bits instead of mismatching words.
module parallel_recv
  import parallel_recv_pkg::*;
(
  input  logic        clk,
  input  logic        rstx,
  input  logic        clr,
  input  logic        divalid,
  input  logic [63:0] din,
  output logic        dovalid,
  output logic [63:0] dout,
  output logic        locked,
  output logic [5:0]  offset,
  output logic        checking,
  output logic [15:0] err_cnt,
  output logic        run_done
);

  state_t       state, state_nxt;
  logic [63:0]  prev, pred, expected, rcv;
  logic [127:0] window;
  logic [10:0]  wcnt;
  logic         hit, mismatch, run_end;
  logic [5:0]   hit_k;
  logic [15:0]  err_inc;
  logic [16:0]  err_sum;

  assign window = {din, prev};
  assign rcv    = window[offset +: 64];

  // Scan downwards so the lowest matching offset wins.
  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    for (int k = 63; k >= 0; k--) begin
      if (window[k +: 64] == MARKER) begin
        hit   = 1'b1;
        hit_k = 6'(k);
      end
    end
  end

  lfsr32x2 u_pred (
    .seed     (pred),
    .word_out (expected)
  );

  assign mismatch = (expected != rcv);
  assign run_end  = (wcnt == 11'(RUN_LEN - 1));
`ifdef ERR_BITCOUNT_EN
  assign err_inc  = {9'd0, popcount64(expected ^ rcv)};
`else
  assign err_inc  = 16'd1;
`endif
  assign err_sum  = {1'b0, err_cnt} + {1'b0, err_inc};

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx)    state <= ST_HUNT;
    else if (clr) state <= ST_HUNT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (divalid) begin
      case (state)
        ST_HUNT:  if (hit) state_nxt = ST_SEED;
        ST_SEED:  state_nxt = ST_CHECK;
        ST_CHECK: begin
          if (hit)          state_nxt = ST_SEED;
          else if (run_end) state_nxt = ST_HUNT;
        end
        default:  state_nxt = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    checking = (state == ST_CHECK);
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      prev <= '0; pred <= '0; wcnt <= '0; locked <= 1'b0; offset <= '0;
      dout <= '0; dovalid <= 1'b0; err_cnt <= '0; run_done <= 1'b0;
    end else if (clr) begin
      prev <= '0; pred <= '0; wcnt <= '0; locked <= 1'b0; offset <= '0;
      dout <= '0; dovalid <= 1'b0; err_cnt <= '0; run_done <= 1'b0;
    end else begin
      run_done <= 1'b0;
      dovalid  <= 1'b0;
      if (divalid) begin
        prev    <= din;
        dout    <= rcv;
        dovalid <= locked;
        case (state)
          ST_HUNT: begin
            if (hit) begin
              offset <= hit_k;
              locked <= 1'b1;
            end
          end
          ST_SEED: begin
            pred <= rcv;
            wcnt <= 11'd1;
          end
          ST_CHECK: begin
            // A marker restarts the run; its word is never scored.
            if (hit) begin
              offset <= hit_k;
            end else begin
              if (mismatch) err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
              pred <= rcv;
              wcnt <= wcnt + 11'd1;
              if (run_end) run_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parallel_recv.sv
// tb/tb_parallel_recv.sv - self-checking bench for parallel_recv
// Vector table, stream scenarios and a bit-level reference model.
module tb_parallel_recv;
  import parallel_recv_pkg::*;

  logic        clk = 1'b0;
  logic        rstx, clr, divalid;
  logic [63:0] din;
  logic        dovalid, locked, checking, run_done;
  logic [63:0] dout;
  logic [5:0]  offset;
  logic [15:0] err_cnt;

  parallel_recv dut (
    .clk(clk), .rstx(rstx), .clr(clr), .divalid(divalid), .din(din),
    .dovalid(dovalid), .dout(dout), .locked(locked), .offset(offset),
    .checking(checking), .err_cnt(err_cnt), .run_done(run_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model
  int          m_state, m_wcnt, m_off, m_err;
  logic [63:0] m_prev, m_pred, m_dout;
  logic        m_locked, m_dov, m_rd;

  function automatic logic [63:0] ref_next(input logic [63:0] w);
    logic [31:0] st;
    logic [63:0] o;
    logic        b;
    st = w[63:32];
    o  = '0;
    for (int j = 0; j < 64; j++) begin
      b    = st[0] ^ st[10] ^ st[30] ^ st[31];
      o[j] = b;
      st   = {b, st[31:1]};
    end
    return o;
  endfunction

  function automatic int find_marker(input logic [127:0] win);
    for (int k = 0; k < 64; k++) if (64'(win >> k) == MARKER) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_wcnt = 0; m_off = 0; m_err = 0;
    m_prev = '0; m_pred = '0; m_dout = '0;
    m_locked = 1'b0; m_dov = 1'b0; m_rd = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic v, input logic [63:0] d);
    logic [127:0] win;
    logic [63:0]  rcv, exp;
    int           hit, inc;
    m_rd = 1'b0; m_dov = 1'b0;
    if (c) begin model_reset(); return; end
    if (!v) return;
    win = {d, m_prev};
    hit = find_marker(win);
    rcv = 64'(win >> m_off);
    m_dout = rcv;
    m_dov  = m_locked;
    if (m_state == 0) begin
      if (hit >= 0) begin m_off = hit; m_locked = 1'b1; m_state = 1; end
    end else if (m_state == 1) begin
      m_pred = rcv; m_wcnt = 1; m_state = 2;
    end else if (hit >= 0) begin
      m_off = hit; m_state = 1;
    end else begin
      exp = ref_next(m_pred);
      if (exp != rcv) begin
`ifdef ERR_BITCOUNT_EN
        inc = $countones(exp ^ rcv);
`else
        inc = 1;
`endif
        m_err = (m_err + inc > 65535) ? 65535 : m_err + inc;
      end
      m_pred = rcv;
      m_wcnt++;
      if (m_wcnt == RUN_LEN) begin m_rd = 1'b1; m_state = 0; end
    end
    m_prev = d;
  endtask

  function automatic logic [89:0] dut_outs();
    return {dovalid, dout, locked, offset, checking, err_cnt, run_done};
  endfunction

  function automatic logic [89:0] model_outs();
    return {m_dov, m_dout, m_locked, 6'(m_off), (m_state == 2), 16'(m_err), m_rd};
  endfunction

  // Run statistics
  int          rd_count, chk_count, abort_count, stray;
  logic        last_chk;
  logic [63:0] dq[$];

  task automatic reset_stats();
    rd_count = 0; chk_count = 0; abort_count = 0; stray = 0;
    last_chk = checking; dq.delete();
  endtask

  task automatic tick(input logic c, input logic v, input logic [63:0] d);
    clr = c; divalid = v; din = d;
    @(posedge clk);
    model_step(c, v, d);
    #1;
    chk("outputs", {38'd0, dut_outs()}, {38'd0, model_outs()});
    if (run_done) rd_count++;
    if (checking) chk_count++;
    if (last_chk && !checking && !run_done && !c) abort_count++;
    last_chk = checking;
    if (dovalid && !v) stray++;
    if (dovalid) dq.push_back(dout);
  endtask

  // Stream builder: bit 0 of each word goes on the wire first
  logic        bq[$];
  logic [63:0] raw[$];
  logic [63:0] data_w[$];

  task automatic push_bits(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) bq.push_back(w[i]);
  endtask

  task automatic build(input int shift, input logic [63:0] seed, input int flip,
                       input int abort_at, input logic [63:0] seed2);
    logic [63:0] w, wv, tmp;
    int          total;
    bq.delete(); raw.delete(); data_w.delete();
    for (int i = 0; i < 3; i++) push_bits(DELAY_ADJ, 64);
    push_bits(DELAY_ADJ, shift);
    push_bits(MARKER, 64);
    total = (abort_at >= 0) ? abort_at + RUN_LEN : RUN_LEN;
    w = seed;
    for (int i = 0; i < total; i++) begin
      if (i == abort_at) begin
        push_bits(DELAY_ADJ, 12);
        push_bits(MARKER, 64);
        w = seed2;
        data_w.delete();
      end
      wv = w;
      if (i == flip) wv[5] = ~wv[5];
      push_bits(wv, 64);
      data_w.push_back(w);
      w = ref_next(w);
    end
    for (int i = 0; i < 3; i++) push_bits(DELAY_ADJ, 64);
    while (bq.size() % 64 != 0) bq.push_back(1'b0);
    for (int j = 0; j < bq.size() / 64; j++) begin
      for (int b = 0; b < 64; b++) tmp[b] = bq[64*j + b];
      raw.push_back(tmp);
    end
  endtask

  task automatic play(input logic gapped);
    int j, p;
    j = 0; p = 0;
    while (j < raw.size()) begin
      if (!gapped || (p % 4 == 0) || (p % 4 == 3)) begin
        tick(1'b0, 1'b1, raw[j]);
        j++;
      end else begin
        tick(1'b0, 1'b0, {$urandom(), $urandom()});
      end
      p++;
    end
  endtask

  function automatic int dout_matches();
    int ok;
    ok = 0;
    for (int i = 0; i < RUN_LEN; i++) if (i < dq.size() && dq[i] == data_w[i]) ok++;
    return ok;
  endfunction

  function automatic logic [63:0] rand_seed();
    return {$urandom() | 32'h1, $urandom()};
  endfunction

  typedef struct {
    logic        c;
    logic        v;
    logic [63:0] d;
    logic [8:0]  exp;   // {locked, offset, checking, dovalid}
  } vec_t;

  vec_t        vt[10];
  logic [63:0] s1;
  int          nruns;

  initial begin
    rstx = 1'b0; clr = 1'b0; divalid = 1'b0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {38'd0, dut_outs()}, 128'd0);
    rstx = 1'b1;
    reset_stats();

    vt[0] = '{1'b0, 1'b1, DELAY_ADJ,                          {1'b0, 6'd0,  1'b0, 1'b0}};
    vt[1] = '{1'b0, 1'b1, MARKER,                             {1'b0, 6'd0,  1'b0, 1'b0}};
    vt[2] = '{1'b0, 1'b1, 64'h0123_4567_89AB_CDEF,            {1'b1, 6'd0,  1'b0, 1'b0}};
    vt[3] = '{1'b0, 1'b0, 64'hDEAD_BEEF_0000_1111,            {1'b1, 6'd0,  1'b0, 1'b0}};
    vt[4] = '{1'b0, 1'b1, 64'h1111_2222_3333_4444,            {1'b1, 6'd0,  1'b1, 1'b1}};
    vt[5] = '{1'b1, 1'b1, 64'h5555_6666_7777_8888,            {1'b0, 6'd0,  1'b0, 1'b0}};
    vt[6] = '{1'b0, 1'b1, {MARKER[43:0], 20'h55555},          {1'b0, 6'd0,  1'b0, 1'b0}};
    vt[7] = '{1'b0, 1'b1, {44'd0, MARKER[63:44]},             {1'b1, 6'd20, 1'b0, 1'b0}};
    vt[8] = '{1'b0, 1'b1, 64'h9999_AAAA_BBBB_CCCC,            {1'b1, 6'd20, 1'b1, 1'b1}};
    vt[9] = '{1'b0, 1'b1, 64'hCAFE_F00D_1234_5678,            {1'b1, 6'd20, 1'b1, 1'b1}};
    for (int i = 0; i < 10; i++) begin
      tick(vt[i].c, vt[i].v, vt[i].d);
      chk($sformatf("vec%0d", i), {119'd0, locked, offset, checking, dovalid}, {119'd0, vt[i].exp});
    end

    // Zero offset, full run
    tick(1'b1, 1'b0, '0); reset_stats();
    build(0, rand_seed(), -1, -1, '0); play(1'b0);
    chk("zero_locked", locked, 1);
    chk("zero_offset", offset, 0);
    chk("zero_compares", chk_count, 1023);
    chk("zero_err", err_cnt, 0);
    chk("zero_run_done", rd_count, 1);
    chk("zero_dout_seq", dout_matches(), RUN_LEN);

    // Shifted by 37, gapless then gapped
    s1 = rand_seed();
    tick(1'b1, 1'b0, '0); reset_stats();
    build(37, s1, -1, -1, '0); play(1'b0);
    chk("shift_offset", offset, 37);
    chk("shift_err", err_cnt, 0);
    chk("shift_dout_seq", dout_matches(), RUN_LEN);
    tick(1'b1, 1'b0, '0); reset_stats();
    play(1'b1);
    chk("gap_offset", offset, 37);
    chk("gap_err", err_cnt, 0);
    chk("gap_run_done", rd_count, 1);
    chk("gap_dout_seq", dout_matches(), RUN_LEN);
    chk("gap_stray_dovalid", stray, 0);

    // Single flipped bit
    tick(1'b1, 1'b0, '0); reset_stats();
    build(0, rand_seed(), 100, -1, '0); play(1'b0);
    chk("flip_err", err_cnt, 1);
    chk("flip_run_done", rd_count, 1);

    // Abort and relock at offset 12
    tick(1'b1, 1'b0, '0); reset_stats();
    build(0, rand_seed(), -1, 500, rand_seed()); play(1'b0);
    chk("abort_offset", offset, 12);
    chk("abort_err", err_cnt, 0);
    chk("abort_reseed", abort_count, 1);
    chk("abort_run_done", rd_count, 1);

    // Synchronous clear mid-run
    tick(1'b1, 1'b0, '0); reset_stats();
    build(0, rand_seed(), 100, -1, '0);
    for (int j = 0; j < 600; j++) tick(1'b0, 1'b1, raw[j]);
    chk("mid_run_checking", checking, 1);
    tick(1'b1, 1'b1, raw[600]);
    chk("clr_outs", {38'd0, dut_outs()}, 128'd0);

    // Asynchronous reset mid-run
    for (int j = 0; j < 600; j++) tick(1'b0, 1'b1, raw[j]);
    #2 rstx = 1'b0;
    #1;
    chk("async_reset_outs", {38'd0, dut_outs()}, 128'd0);
    model_reset();
    last_chk = 1'b0;
    #2 rstx = 1'b1;
    for (int j = 601; j < 700; j++) tick(1'b0, 1'b1, raw[j]);
    chk("relock_needs_marker", locked, 0);

    // Error counter saturation with random payloads
`ifdef ERR_BITCOUNT_EN
    nruns = 3;
`else
    nruns = 65;
`endif
    tick(1'b1, 1'b0, '0); reset_stats();
    for (int r = 0; r < nruns; r++) begin
      tick(1'b0, 1'b1, MARKER);
      for (int i = 0; i < RUN_LEN; i++) tick(1'b0, 1'b1, {$urandom(), $urandom()});
    end
    tick(1'b0, 1'b1, DELAY_ADJ);
    chk("err_saturated", err_cnt, 16'hFFFF);
    chk("sat_run_done", rd_count, nruns);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
